// File: rtl/seq_mul_iter.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned per request.
// Signed operands are reduced to magnitudes and the sign is applied once, in FIX.
module seq_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, mplier;
    logic [2*WIDTH:0]     acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     acc_nxt;

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    always_comb begin
        a_mag   = (sgn && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
        b_mag   = (sgn && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
        sum     = acc[2*WIDTH:WIDTH] + {1'b0, (mplier[0] ? mcand : '0)};
        acc_nxt = {sum, acc[WIDTH-1:0]} >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            out    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand  <= a_mag;
                    mplier <= b_mag;
                    neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc    <= '0;
                    cnt    <= CW'(WIDTH);
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                FIX: out <= neg ? (~acc[2*WIDTH-1:0]) + (2*WIDTH)'(1) : acc[2*WIDTH-1:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_iter.sv
// Directed bench for seq_mul_iter: vector table at WIDTH=8, handshake corner
// sequences, and an exhaustive sweep of a WIDTH=4 instance.
module tb_seq_mul_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv8, ir8, s8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;
    logic        iv4, ir4, s4, ov4, or4;
    logic [3:0]  a4, b4;
    logic [7:0]  out4;

    seq_mul_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sgn(s8), .out_valid(ov8), .out_ready(or8), .out(out8));
    seq_mul_iter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .sgn(s4), .out_valid(ov4), .out_ready(or4), .out(out4));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic accept8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts);
        @(negedge clk);
        a8 = ta; b8 = tb_; s8 = ts; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    // lat counts rising edges, the accepting edge being the first
    task automatic wait_ov8(input int start, output int lat);
        lat = start;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov8) chk("timeout8", 32'(ov8), 32'd1);
    endtask

    task automatic mul8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                        output logic [15:0] res, output int lat);
        accept8(ta, tb_, ts);
        wait_ov8(1, lat);
        res = out8;
        @(posedge clk); #1;
    endtask

    task automatic mul4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                        output logic [7:0] res, output int lat);
        @(negedge clk);
        a4 = ta; b4 = tb_; s4 = ts; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov4) chk("timeout4", 32'(ov4), 32'd1);
        res = out4;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        logic [7:0]  r4;
        int          lat;
        int          hits;

        vt[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vt[1]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vt[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vt[3]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vt[4]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vt[5]  = '{8'h00, 8'h55, 1'b0, 16'h0000};
        vt[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vt[7]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vt[8]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        vt[9]  = '{8'h0C, 8'h0D, 1'b0, 16'h009C};
        vt[10] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
        vt[11] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; s8 = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; s4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out", 32'(out8), 32'd0);
        chk("rst_ov", 32'(ov8), 32'd0);
        chk("rst_ir", 32'(ir8), 32'd1);

        for (int i = 0; i < 12; i++) begin
            mul8(vt[i].a, vt[i].b, vt[i].s, r, lat);
            chk($sformatf("vec%0d_out", i), 32'(r), 32'(vt[i].exp));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd10);
        end

        // backpressure: 11*13 = 143 held for 5 cycles
        or8 = 1'b0;
        accept8(8'd11, 8'd13, 1'b0);
        wait_ov8(1, lat);
        chk("bp_lat", 32'(lat), 32'd10);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out", 32'(out8), 32'h8F);
            chk("bp_ov", 32'(ov8), 32'd1);
            chk("bp_ir", 32'(ir8), 32'd0);
        end
        @(negedge clk) or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_cons_ov", 32'(ov8), 32'd0);
        chk("bp_cons_ir", 32'(ir8), 32'd1);
        chk("bp_keep_out", 32'(out8), 32'h8F);

        // request during CALC is ignored; operands changing mid-flight too
        accept8(8'd3, 8'd4, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; s8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        wait_ov8(4, lat);
        chk("busy_out", 32'(out8), 32'd12);
        chk("busy_lat", 32'(lat), 32'd10);
        @(posedge clk); #1;
        hits = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (ov8 || !ir8) hits++;
        end
        chk("busy_no_second", 32'(hits), 32'd0);

        // reset in 4th CALC cycle, in_valid also high on that edge
        accept8(8'h55, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv8 = 1'b0;
        chk("midrst_ov", 32'(ov8), 32'd0);
        chk("midrst_out", 32'(out8), 32'd0);
        chk("midrst_ir", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        chk("midrst_idle", 32'(ir8), 32'd1);
        mul8(8'd2, 8'd3, 1'b0, r, lat);
        chk("after_rst_out", 32'(r), 32'd6);
        chk("after_rst_lat", 32'(lat), 32'd10);

        // WIDTH=4 exhaustive, both modes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    int ea, eb, p;
                    logic [7:0] e8;
                    ea = (s == 1 && i >= 8) ? i - 16 : i;
                    eb = (s == 1 && j >= 8) ? j - 16 : j;
                    p  = ea * eb;
                    e8 = p[7:0];
                    mul4(4'(i), 4'(j), s[0], r4, lat);
                    chk($sformatf("w4 s=%0d %0d*%0d", s, i, j), 32'(r4), 32'(e8));
                    chk("w4_lat", 32'(lat), 32'd6);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
